// File: rtl/detector_pkg.sv
// Shared types and constants for the threshold-detector frame controller.
//   state_t  : frame sequencer states
//   report_t : per-frame report word layout (occupied | rsvd | frame_idx | hits)
package detector_pkg;

  localparam int unsigned THRESH_W   = 16;
  localparam logic [THRESH_W-1:0] THRESH_RST = 16'hFFFF;
  localparam int unsigned REPORT_W   = 32;

  // Report field positions
  localparam int unsigned HITS_LSB   = 0;
  localparam int unsigned HITS_MSB   = 15;
  localparam int unsigned IDX_LSB    = 16;
  localparam int unsigned IDX_MSB    = 27;
  localparam int unsigned OCC_BIT    = 31;

  localparam int unsigned HITS_W      = HITS_MSB - HITS_LSB + 1;
  localparam int unsigned FRAME_IDX_W = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned RSVD_W      = OCC_BIT - IDX_MSB - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  typedef struct packed {
    logic                   occupied;
    logic [RSVD_W-1:0]      rsvd;
    logic [FRAME_IDX_W-1:0] frame_idx;
    logic [HITS_W-1:0]      hits;
  } report_t;

endpackage

// File: rtl/occupancy_hyst.sv
// Dwell hysteresis for band occupancy: counts consecutive hot / cold frames and
// sets or clears the occupied flag once a run reaches the dwell length.
//   frame_end        : one-cycle pulse, a frame was completed this cycle
//   hot              : verdict for that frame (valid with frame_end)
//   dwell            : run length to flip occupancy (0 behaves as 1)
//   occupied         : registered occupancy decision
//   occupied_next_c  : value occupied takes at the coming edge (for the report)
module occupancy_hyst #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_end,
  input  logic               hot,
  input  logic [DWELL_W-1:0] dwell,
  output logic               occupied,
  output logic               occupied_next_c
);

  localparam int unsigned EXT_W = DWELL_W + 1;

  logic [DWELL_W-1:0] hot_cnt;
  logic [DWELL_W-1:0] cold_cnt;
  logic [DWELL_W-1:0] hot_cnt_d;
  logic [DWELL_W-1:0] cold_cnt_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W-1:0] run_capped;
  logic [EXT_W-1:0]   run_inc;
  logic               run_reached;

  // Extend the run matching this frame's verdict; the other run restarts.
  always_comb begin
    dwell_eff       = (dwell == '0) ? DWELL_W'(1) : dwell;
    run_inc         = EXT_W'(hot ? hot_cnt : cold_cnt) + EXT_W'(1);
    run_reached     = (run_inc >= EXT_W'(dwell_eff));
    run_capped      = run_reached ? dwell_eff : run_inc[DWELL_W-1:0];
    hot_cnt_d       = hot_cnt;
    cold_cnt_d      = cold_cnt;
    occupied_next_c = occupied;
    if (frame_end) begin
      if (hot) begin
        hot_cnt_d  = run_capped;
        cold_cnt_d = '0;
        if (run_reached) occupied_next_c = 1'b1;
      end else begin
        cold_cnt_d = run_capped;
        hot_cnt_d  = '0;
        if (run_reached) occupied_next_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hot_cnt  <= '0;
      cold_cnt <= '0;
      occupied <= 1'b0;
    end else begin
      hot_cnt  <= hot_cnt_d;
      cold_cnt <= cold_cnt_d;
      occupied <= occupied_next_c;
    end
  end

endmodule

// File: rtl/detector_frame_ctrl.sv
// Frame sequencer / configurator for the threshold detector.
// Drives the detector threshold, counts exceedance flags per tlast-delimited
// frame, applies dwell hysteresis and emits one 32-bit report per frame.
// Config writes are shadowed and only take effect on frame boundaries.
//   enable                         : run detection while high
//   cfg_wr, cfg_thresh/min_hits/dwell : shadow config write
//   det_thresh                     : threshold into the detector
//   s_t*                           : flag stream in (bit0 = exceed)
//   m_t*                           : per-frame report stream out
//   occupied, cfg_pending          : status levels
module detector_frame_ctrl
  import detector_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_wr,
  input  logic [THRESH_W-1:0] cfg_thresh,
  input  logic [CNT_W-1:0]    cfg_min_hits,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  output logic [THRESH_W-1:0] det_thresh,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [7:0]          s_tdata,
  input  logic                s_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [REPORT_W-1:0] m_tdata,
  output logic                occupied,
  output logic                cfg_pending
);

  localparam int unsigned SUM_W = CNT_W + 1;

  state_t                 state;
  state_t                 state_d;
  logic [CNT_W-1:0]       hits;
  logic [CNT_W-1:0]       hits_sum_c;
  logic [SUM_W-1:0]       hits_ext_c;
  logic [CNT_W-1:0]       min_hits;
  logic [CNT_W-1:0]       sh_min_hits;
  logic [DWELL_W-1:0]     dwell;
  logic [DWELL_W-1:0]     sh_dwell;
  logic [THRESH_W-1:0]    sh_thresh;
  logic [FRAME_IDX_W-1:0] frame_idx;
  logic                   beat_c;
  logic                   tlast_beat_c;
  logic                   boundary_c;
  logic                   frame_end_c;
  logic                   handshake_c;
  logic                   hot_c;
  logic                   occ_next_c;
  report_t                report_c;
  logic                   unused_tdata;

  assign beat_c       = s_tvalid && s_tready;
  assign tlast_beat_c = beat_c && s_tlast;
  assign boundary_c   = tlast_beat_c && ((state == SYNC) || (state == RUN));
  assign frame_end_c  = tlast_beat_c && (state == RUN);
  assign handshake_c  = m_tvalid && m_tready;
  assign unused_tdata = ^s_tdata[7:1];

  // Saturating running count including the current beat's flag.
  assign hits_ext_c = {1'b0, hits} + SUM_W'(s_tdata[0]);
  assign hits_sum_c = hits_ext_c[CNT_W] ? {CNT_W{1'b1}} : hits_ext_c[CNT_W-1:0];
  assign hot_c      = (hits_sum_c >= min_hits);

  always_comb begin
    report_c           = '0;
    report_c.hits      = HITS_W'(hits_sum_c);
    report_c.frame_idx = frame_idx;
    report_c.occupied  = occ_next_c;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (enable) state_d = SYNC;
      SYNC: begin
        if (!enable)           state_d = IDLE;
        else if (tlast_beat_c) state_d = RUN;
      end
      RUN:     if (tlast_beat_c) state_d = REPORT;
      REPORT:  if (handshake_c) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_tready <= 1'b0;
      m_tvalid <= 1'b0;
    end else begin
      state    <= state_d;
      s_tready <= (state_d == SYNC) || (state_d == RUN);
      m_tvalid <= (state_d == REPORT);
    end
  end

  // Hit counter, report register, frame index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits      <= '0;
      m_tdata   <= '0;
      frame_idx <= '0;
    end else begin
      if (frame_end_c) begin
        hits    <= '0;
        m_tdata <= report_c;
      end else if (beat_c && (state == RUN)) begin
        hits    <= hits_sum_c;
      end
      if (handshake_c) frame_idx <= frame_idx + FRAME_IDX_W'(1);
    end
  end

  // Shadow config: immediate in IDLE, write-through on a boundary, else pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_thresh  <= THRESH_RST;
      min_hits    <= CNT_W'(1);
      dwell       <= DWELL_W'(1);
      sh_thresh   <= THRESH_RST;
      sh_min_hits <= CNT_W'(1);
      sh_dwell    <= DWELL_W'(1);
      cfg_pending <= 1'b0;
    end else if (cfg_wr && (boundary_c || (state == IDLE))) begin
      det_thresh  <= cfg_thresh;
      min_hits    <= cfg_min_hits;
      dwell       <= cfg_dwell;
      sh_thresh   <= cfg_thresh;
      sh_min_hits <= cfg_min_hits;
      sh_dwell    <= cfg_dwell;
      cfg_pending <= 1'b0;
    end else if (boundary_c && cfg_pending) begin
      det_thresh  <= sh_thresh;
      min_hits    <= sh_min_hits;
      dwell       <= sh_dwell;
      cfg_pending <= 1'b0;
    end else if (cfg_wr) begin
      sh_thresh   <= cfg_thresh;
      sh_min_hits <= cfg_min_hits;
      sh_dwell    <= cfg_dwell;
      cfg_pending <= 1'b1;
    end
  end

  // Hysteresis judges the completed frame with the config it ran under.
  occupancy_hyst #(
    .DWELL_W (DWELL_W)
  ) u_hyst (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_end       (frame_end_c),
    .hot             (hot_c),
    .dwell           (dwell),
    .occupied        (occupied),
    .occupied_next_c (occ_next_c)
  );

endmodule
